cru_pi_reset_seq: RTL

- Downstream consumer of the 4-bit CRU output register driven by the TI-99/4A.
- Moves the CRU bits from the TI CRU-clock domain into the CPLD system clock domain.
- Turns a rising edge on CRU bit 0 into a timed, glitch-free reset pulse to the Raspberry Pi.
- Passes the remaining bits to the rest of the design as synchronized, qualified levels (DSR enable, two aux lines).

---
 rtl/cru_pi_reset_seq_if.sv | 31 +++
 rtl/cru_pi_reset_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cru_pi_reset_seq_if.sv
// rtl/cru_pi_reset_seq_if.sv - CRU bit inputs and Pi reset sequencer outputs bundle
//
// Purpose: groups the CRU register lines and the sequencer's qualified outputs.
// Signals:
//   cru_bits   [0:3] CRU register outputs (bit0 reset request, bit1 DSR enable, bits2-3 aux)
//   pi_reset_n       active-low reset to the Raspberry Pi
//   dsr_en           synchronized DSR enable, forced off while the Pi is held in reset
//   aux        [0:1] synchronized cru_bits[2:3]
//   busy             high while a reset pulse or its holdoff is in progress
//   pulse_done       one-clk strobe on the final holdoff cycle
//   rst_count  [0:3] reset pulses issued, saturating at 15
// Modports: master drives cru_bits (TI side), slave is the sequencer.
interface cru_pi_reset_seq_if;
    logic [0:3] cru_bits;
    logic       pi_reset_n;
    logic       dsr_en;
    logic [0:1] aux;
    logic       busy;
    logic       pulse_done;
    logic [0:3] rst_count;

    modport master (
        output cru_bits,
        input  pi_reset_n, dsr_en, aux, busy, pulse_done, rst_count
    );

    modport slave (
        input  cru_bits,
        output pi_reset_n, dsr_en, aux, busy, pulse_done, rst_count
    );
endinterface

// File: rtl/cru_pi_reset_seq.sv
// rtl/cru_pi_reset_seq.sv - CRU bit synchronizer and timed Raspberry Pi reset pulse sequencer
//
// Purpose: brings the TI-99/4A CRU output bits into the clk domain, turns a rising
// edge on bit0 into a RESET_CYCLES-long active-low Pi reset followed by a
// HOLDOFF_CYCLES lockout, and passes bit1 (DSR enable) and bits2-3 (aux) on as levels.
// Ports:
//   clk    CPLD system clock
//   reset  asynchronous active-high reset
//   bus    cru_pi_reset_seq_if.slave (cru_bits in; pi_reset_n, dsr_en, aux, busy,
//          pulse_done, rst_count out)
module cru_pi_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int RESET_CYCLES   = 1000,
    parameter int HOLDOFF_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      reset,
    cru_pi_reset_seq_if.slave         bus
);

    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0]       WARM_LAST  = 3'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

    logic [0:3]       sync_q [SYNC_STAGES];
    logic [0:3]       synced;
    logic             edge_q;
    logic [2:0]       warm_q;
    logic             warm_done;
    logic             req_rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [3:0]       rst_count_q, rst_count_d;
    logic             pi_reset_n_q;
    logic             enter_assert;
    logic             pulse_done;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == WARM_LAST);
    // The warm-up gate stops a bit0 that is already high at reset release from
    // looking like a rising edge while the chain and edge flop fill.
    assign req_rise  = synced[0] & ~edge_q & warm_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            edge_q <= 1'b0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= bus.cru_bits;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            edge_q <= synced[0];
            if (!warm_done) warm_q <= warm_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            rst_count_q  <= '0;
            pi_reset_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            rst_count_q  <= rst_count_d;
            // Registered from the next state so the Pi reset line never glitches.
            pi_reset_n_q <= (state_d != ASSERT);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        enter_assert = 1'b0;
        pulse_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d      = ASSERT;
                    cnt_d        = RESET_LOAD;
                    enter_assert = 1'b1;
                end
            end
            ASSERT: begin
                // Requests here are dropped on purpose: the pulse is never stretched.
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLDOFF: begin
                if (req_rise) pending_d = 1'b1;
                if (cnt_q == '0) begin
                    pulse_done = 1'b1;
                    if (pending_q || req_rise) begin
                        state_d      = ASSERT;
                        cnt_d        = RESET_LOAD;
                        pending_d    = 1'b0;
                        enter_assert = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
        rst_count_d = rst_count_q;
        if (enter_assert && rst_count_q != 4'd15) rst_count_d = rst_count_q + 4'd1;
    end

    assign bus.pi_reset_n = pi_reset_n_q;
    assign bus.dsr_en     = synced[1] & (state_q != ASSERT);
    assign bus.aux        = synced[2:3];
    // busy drops together with pulse_done unless the final holdoff cycle re-arms ASSERT.
    assign bus.busy       = (state_q != IDLE) && (state_d != IDLE);
    assign bus.pulse_done = pulse_done;
    assign bus.rst_count  = rst_count_q;

endmodule
